// File: rtl/alu_m_ext.sv
// alu_m_ext: RV32M multiply/divide unit with a single registered 32-bit result
// Ports: clk, reset (sync, active-high), data1 = rs1 (dividend/multiplicand),
//        data2 = rs2 (divisor/multiplier), alu_control = 5-bit op select, result = registered output
module alu_m_ext (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [4:0]  alu_control,
  output logic [31:0] result
);
  logic        a_sgn, b_sgn, d_sgn, dz, ovf;
  logic [63:0] op_a, op_b, prod;
  logic [31:0] dvd, dvs, dvs_nz, q, r, div_res, rem_res, result_d, result_q;
  always_comb begin
    a_sgn    = alu_control[2:0] == 3'b001 || alu_control[2:0] == 3'b011;
    b_sgn    = alu_control[2:0] == 3'b001;
    op_a     = {{32{a_sgn & data1[31]}}, data1};
    op_b     = {{32{b_sgn & data2[31]}}, data2};
    prod     = op_a * op_b;
    d_sgn    = ~alu_control[0];
    dvd      = d_sgn && data1[31] ? -data1 : data1;
    dvs      = d_sgn && data2[31] ? -data2 : data2;
    dz       = data2 == 32'h0;
    ovf      = d_sgn && data1 == 32'h8000_0000 && data2 == 32'hFFFF_FFFF;
    dvs_nz   = dz ? 32'h1 : dvs;
    q        = dvd / dvs_nz;
    r        = dvd % dvs_nz;
    div_res  = dz ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : d_sgn && (data1[31] ^ data2[31]) ? -q : q;
    rem_res  = dz ? data1 : ovf ? 32'h0 : d_sgn && data1[31] ? -r : r;
    result_d = alu_control[4:3] != 2'b01 ? 32'h0 :
               alu_control[2] ? (alu_control[1] ? rem_res : div_res) :
               alu_control[1:0] == 2'b00 ? prod[31:0] : prod[63:32];
  end
  always_ff @(posedge clk) result_q <= reset ? 32'h0 : result_d;
  assign result = result_q;
endmodule

// File: tb/tb_alu_m_ext.sv
// tb_alu_m_ext: randomized and directed self-checking bench for alu_m_ext
module tb_alu_m_ext;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data1 = 32'h0, data2 = 32'h0;
  logic [4:0]  alu_control = 5'h0;
  logic [31:0] result;
  int n_cmp = 0, n_err = 0;

  localparam logic [4:0] MUL = 5'b01000, MULH = 5'b01001, MULHU = 5'b01010, MULHSU = 5'b01011;
  localparam logic [4:0] DIV = 5'b01100, DIVU = 5'b01101, REM = 5'b01110, REMU = 5'b01111;

  alu_m_ext dut (.clk(clk), .reset(reset), .data1(data1), .data2(data2),
                 .alu_control(alu_control), .result(result));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, b});
    longint p;
    case (op)
      MUL:    begin p = sa * sb; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      REMU: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_control = op; data1 = a; data2 = b;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(MUL, 32'd5, 32'd7);
      n_cmp++;
      if (result !== 32'h0) begin n_err++; $display("FAIL reset_%0d: got %h expected %h", i, result, 32'h0); end
    end
    reset = 1'b0;
    step(MUL, 32'd5, 32'd7);
    n_cmp++;
    if (result !== 32'd35) begin n_err++; $display("FAIL reset_release: got %h expected %h", result, 32'd35); end
  endtask

  task automatic test_directed;
    logic [4:0]  ops [18] = '{MUL, MULH, MULHU, MULHSU, MULHU, MULH, DIV, REM, DIVU, REMU,
                              DIV, DIVU, REM, REMU, DIV, REM, 5'b00000, 5'b10000};
    logic [31:0] as  [18] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd4000000000, 32'hFFFF_FFF7,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 32'hFFFF_FFEC,
                              32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd1234, 32'd1234, 32'd1234, 32'd1234,
                              32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
    logic [31:0] bs  [18] = '{32'd3, 32'd3, 32'd2, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd6, 32'd6, 32'd6, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd3};
    logic [31:0] es  [18] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                              32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h2AAA_AAA7, 32'd2,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1234, 32'd1234,
                              32'h8000_0000, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 18; i++) begin
      step(ops[i], as[i], bs[i]);
      n_cmp++;
      if (result !== es[i]) begin
        n_err++;
        $display("FAIL directed_%0d op=%b a=%h b=%h: got %h expected %h", i, ops[i], as[i], bs[i], result, es[i]);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [4:0]  op;
    logic [31:0] a, b, exp;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(8 + $urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp = model(op, a, b);
      step(op, a, b);
      n_cmp++;
      if (result !== exp) begin
        n_err++;
        $display("FAIL random_%0d op=%b a=%h b=%h: got %h expected %h", i, op, a, b, result, exp);
      end
      data1 = ~a; data2 = b ^ 32'h5A5A_5A5A; alu_control = op ^ 5'b00101;
      #2;
      n_cmp++;
      if (result !== exp) begin n_err++; $display("FAIL hold_%0d: got %h expected %h", i, result, exp); end
    end
  endtask

  task automatic test_back_to_back;
    step(MUL, 32'd6, 32'd7);
    n_cmp++;
    if (result !== 32'd42) begin n_err++; $display("FAIL b2b_mul: got %h expected %h", result, 32'd42); end
    step(DIVU, 32'd100, 32'd9);
    n_cmp++;
    if (result !== 32'd11) begin n_err++; $display("FAIL b2b_divu: got %h expected %h", result, 32'd11); end
    step(5'b00000, 32'd100, 32'd9);
    n_cmp++;
    if (result !== 32'h0) begin n_err++; $display("FAIL b2b_none: got %h expected %h", result, 32'h0); end
    reset = 1'b1;
    step(MUL, 32'd6, 32'd7);
    n_cmp++;
    if (result !== 32'h0) begin n_err++; $display("FAIL b2b_reset: got %h expected %h", result, 32'h0); end
    reset = 1'b0;
    step(REMU, 32'd100, 32'd9);
    n_cmp++;
    if (result !== 32'd1) begin n_err++; $display("FAIL b2b_after_reset: got %h expected %h", result, 32'd1); end
  endtask

  initial begin
    #2;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_m_ext.md
# alu_m_ext

RV32M multiply/divide execution unit for the RV32IM pipelined processor's EX stage. It computes all eight M-extension operations on two 32-bit operands selected by a 5-bit ALU control code and presents the 32-bit result through an output register. It sits alongside the base-integer ALU; the EX-stage mux chooses between their results.

## Interface

Parameters:
- none (datapath width fixed at 32 bits).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock, no asynchronous path.
- `data1`  in  32  operand rs1 (dividend / multiplicand).
- `data2`  in  32  operand rs2 (divisor / multiplier).
- `alu_control`  in  5  operation select (encodings below).
- `result`  out  32  registered operation result.

## Operation

Encodings of `alu_control` (bit 3 set = M-extension group):
- 5'b01000 MUL: low 32 bits of data1 × data2. Signedness is irrelevant for the low word.
- 5'b01001 MULH: high 32 bits of signed(data1) × signed(data2), using a 64-bit product.
- 5'b01010 MULHU: high 32 bits of unsigned(data1) × unsigned(data2).
- 5'b01011 MULHSU: high 32 bits of signed(data1) × unsigned(data2). Sign-extend data1 and zero-extend data2 to 64 bits before multiplying.
- 5'b01100 DIV: signed quotient, truncated toward zero.
- 5'b01101 DIVU: unsigned quotient.
- 5'b01110 REM: signed remainder. Its sign follows the dividend.
- 5'b01111 REMU: unsigned remainder.
- any other code: result register loads 32'h0000_0000.

Division corner cases (RISC-V spec, no traps):
- Divide by zero (data2 == 0):
  - DIV and DIVU return 32'hFFFF_FFFF.
  - REM and REMU return data1.
- Signed overflow (data1 == 32'h8000_0000, data2 == 32'hFFFF_FFFF):
  - DIV returns 32'h8000_0000.
  - REM returns 0.
- These cases must be detected explicitly. Do not rely on simulator `/` or `%` behaviour for them.

All arithmetic is computed combinationally from the current inputs. Only the final 32-bit selection is registered.

## Timing

- Latency is 1 cycle. The result for inputs present before rising edge N is valid on `result` after edge N and holds until edge N+1.
- Throughput is one operation per cycle. No handshake, no stall, no busy signal.
- Reset: if `reset` is high at a rising edge, `result` becomes 32'h0000_0000. Reset takes priority over any operation.
- Deasserting reset: the first edge with `reset` low registers the operation then present on the inputs.
- Asserting reset mid-stream discards the pending computation, with no residual state.
- Input changes between edges do not affect `result` until the next edge.

## Test plan

- Reset: assert `reset` for 2 cycles with data1=5, data2=7, alu_control=MUL -> `result` = 0. After release, the next edge gives 35.
- Multiply, signed low/high (data1=-7 (32'hFFFF_FFF9), data2=3):
  - MUL -> 32'hFFFF_FFEB (-21).
  - MULH -> 32'hFFFF_FFFF (-1).
- Multiply, unsigned/mixed high:
  - data1=32'd4000000000, data2=2, MULHU -> 1.
  - data1=-9, data2=5, MULHSU -> 32'hFFFF_FFFF (-1).
  - data1=32'hFFFF_FFFF, data2=32'hFFFF_FFFF: MULHU -> 32'hFFFF_FFFE; MULH -> 0.
- Divide/remainder, normal (data1=-20, data2=6):
  - DIV -> -3.
  - REM -> -2.
  - DIVU -> 32'h2AAA_AAA7.
  - REMU -> 2.
- Division corners:
  - data2=0, data1=1234: DIV and DIVU -> 32'hFFFF_FFFF; REM and REMU -> 1234.
  - data1=32'h8000_0000, data2=-1: DIV -> 32'h8000_0000; REM -> 0.
- Pipeline behaviour: issue back-to-back ops on consecutive cycles (MUL 6×7, DIVU 100/9, code 5'b00000) -> 42, 11, 0 on successive edges. Then assert reset on the 4th edge -> 0.
